// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues 16-bit reads to a synchronous memory and
// queues {word, pc} pairs in a small prefetch FIFO for the decoder.
//
// Output handshake (instr_valid / instr_ready): instr_valid is high whenever
// the FIFO head holds a word. A transfer happens on a rising edge where both
// are high. While instr_valid is high and instr_ready is low, instr_data and
// instr_pc hold their values. instr_ready with instr_valid low does nothing.
// A redirect flushes the FIFO and takes priority over a transfer in the same
// cycle.
module fetch_unit #(
  parameter int MEM_DEPTH  = 8192,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int FIFO_DEPTH = 4,
  parameter int RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  en,
  output logic                  rd_en,
  output logic [1:0]            wr_en,
  input  logic [15:0]           din,
  input  logic                  run,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [15:0]           instr_data,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  state_dbg
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 1;
  localparam logic [OW-1:0] DEPTH_L = OW'(FIFO_DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] tag_pc;
  logic                  inflight;
  logic [CW-1:0]         count;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [15:0]           fifo_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc   [FIFO_DEPTH];
  logic [OW-1:0]         occupancy;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  unused_redirect_lsb;

  // Reserve a FIFO slot for the outstanding read so a response always fits.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};

  assign addr        = fetch_pc;
  assign en          = issue;
  assign rd_en       = issue;
  assign wr_en       = 2'b00;
  assign instr_valid = (count != '0);
  assign instr_data  = fifo_data[rd_ptr];
  assign instr_pc    = fifo_pc[rd_ptr];
  assign push        = inflight && !redirect;
  assign pop         = instr_valid && instr_ready && !redirect;
  assign state_dbg   = (state == RUN);

  // Instructions are halfword aligned; the low address bit is dropped.
  assign unused_redirect_lsb = redirect_pc[0];

  // State register: run is sampled each edge and takes effect next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and issue decision.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (run) state_next = RUN;
      end
      RUN: begin
        if (!run) state_next = IDLE;
        issue = !redirect && (occupancy < DEPTH_L);
      end
      default: state_next = IDLE;
    endcase
  end

  // Fetch pointer and the single outstanding read tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= ADDR_WIDTH'(RESET_PC);
      tag_pc   <= '0;
      inflight <= 1'b0;
    end else begin
      if (redirect) begin
        fetch_pc <= {redirect_pc[ADDR_WIDTH-1:1], 1'b0};
      end else if (issue) begin
        fetch_pc <= fetch_pc + ADDR_WIDTH'(2);
      end
      if (issue) tag_pc <= fetch_pc;
      inflight <= issue;
    end
  end

  // Prefetch FIFO: push the returning word, pop on handshake, flush on redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= din;
        fifo_pc[wr_ptr]   <= tag_pc;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule
